// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver and make/break scan-code decoder
// Conditions the PS/2 lines, validates 11-bit frames and tracks the held key.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] ps2_byte,
  output logic       ps2_state,
  output logic       byte_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [15:0] TMO_LIM    = 16'(TIMEOUT_CYCLES);
  localparam logic [7:0]  CODE_BREAK = 8'hF0;
  localparam logic [7:0]  CODE_EXT   = 8'hE0;

  logic                  clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_lvl, filt_nxt, fall;

  state_t      state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        par_ok, par_ok_n;
  logic [15:0] tmo, tmo_n;
  logic        accept, err;
  logic        break_pend, ext_pend;

  // Bus idles high, so synchronizers and filter come out of reset at 1.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_sr  <= '1;
      filt_lvl <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clk_s1   <= ps2k_clk;
      clk_s2   <= clk_s1;
      dat_s1   <= ps2k_data;
      dat_s2   <= dat_s1;
      filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_s2};
      filt_lvl <= filt_nxt;
      fall     <= filt_lvl & ~filt_nxt;
    end
  end

  always_comb begin
    filt_nxt = filt_lvl;
    if (&filt_sr)
      filt_nxt = 1'b1;
    else if (~|filt_sr)
      filt_nxt = 1'b0;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_ok  <= 1'b0;
      tmo     <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par_ok  <= par_ok_n;
      tmo     <= tmo_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_ok_n  = par_ok;
    tmo_n     = '0;
    accept    = 1'b0;
    err       = 1'b0;
    if (state != S_IDLE && !fall)
      tmo_n = (tmo == 16'hFFFF) ? tmo : tmo + 16'd1;
    case (state)
      S_IDLE: begin
        if (fall && !dat_s2) begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_n = {dat_s2, shift[7:1]};
          if (bit_cnt == 3'd7)
            state_n = S_PARITY;
          else
            bit_cnt_n = bit_cnt + 3'd1;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_ok_n = ^{shift, dat_s2};
          state_n  = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_n = S_IDLE;
          if (par_ok && dat_s2)
            accept = 1'b1;
          else
            err = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A stalled keyboard abandons the frame; an edge in the same cycle wins.
    if (state != S_IDLE && !fall && tmo >= TMO_LIM) begin
      state_n = S_IDLE;
      tmo_n   = '0;
      err     = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ps2_byte   <= '0;
      ps2_state  <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= err;
      if (accept) begin
        if (shift == CODE_BREAK) begin
          break_pend <= 1'b1;
        end else if (shift == CODE_EXT) begin
          ext_pend <= 1'b1;
        end else begin
          // Extended keys report their low byte, so the prefix only needs retiring here.
          if (ext_pend)
            ext_pend <= 1'b0;
          break_pend <= 1'b0;
          if (!break_pend) begin
            ps2_byte   <= shift;
            ps2_state  <= 1'b1;
            byte_valid <= 1'b1;
          end else if (shift == ps2_byte) begin
            ps2_state <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - randomized and directed bench for ps2_key_decoder
// A key-tracking model predicts every visible output event; one process checks them.
module tb_ps2_key_decoder;

  localparam int H   = 25;
  localparam int TMO = 2000;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       ps2k_clk = 1'b1;
  logic       ps2k_data = 1'b1;
  logic [7:0] ps2_byte;
  logic       ps2_state;
  logic       byte_valid;
  logic       frame_err;

  always #10 clk_in = ~clk_in;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .ps2k_clk   (ps2k_clk),
    .ps2k_data  (ps2k_data),
    .ps2_byte   (ps2_byte),
    .ps2_state  (ps2_state),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic       e;
    logic [7:0] b;
    logic       s;
  } ev_t;

  ev_t        q[$];
  logic [7:0] m_byte = 8'h00;
  logic       m_state = 1'b0;
  logic       m_brk = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic       last_state = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key-tracking model: only visible output changes are queued as events.
  task automatic model_frame(input logic [7:0] code, input bit good);
    ev_t e;
    if (!good) begin
      e = '{1'b0, 1'b1, m_byte, m_state};
      q.push_back(e);
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else if (code != 8'hE0) begin
      if (!m_brk) begin
        m_byte  = code;
        m_state = 1'b1;
        e = '{1'b1, 1'b0, m_byte, 1'b1};
        q.push_back(e);
      end else begin
        m_brk = 1'b0;
        if (code == m_byte && m_state) begin
          m_state = 1'b0;
          e = '{1'b0, 1'b0, m_byte, 1'b0};
          q.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk_in) begin
    ev_t e;
    if (reset) begin
      last_byte  = 8'h00;
      last_state = 1'b0;
    end else begin
      if (byte_valid && frame_err)
        chk("pulse_overlap", {byte_valid, frame_err}, 2'b00);
      if (byte_valid || frame_err || ps2_byte != last_byte || ps2_state != last_state) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {byte_valid, frame_err, ps2_byte, ps2_state}, {2'b00, last_byte, last_state});
        end else begin
          e = q.pop_front();
          chk("event_pulses", {byte_valid, frame_err}, {e.v, e.e});
          chk("event_byte", ps2_byte, e.b);
          chk("event_state", ps2_state, e.s);
        end
        last_byte  = ps2_byte;
        last_state = ps2_state;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    ps2k_data = b;
    wait_cyc(5);
    ps2k_clk = 1'b0;
    wait_cyc(H);
    ps2k_clk = 1'b1;
    if (glitch) begin
      wait_cyc(12);
      ps2k_clk = 1'b0;
      wait_cyc(3);
      ps2k_clk = 1'b1;
      wait_cyc(H - 20);
    end else begin
      wait_cyc(H - 5);
    end
  endtask

  task automatic send_bits(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                           input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++)
      drive_bit(bits[i], i == glitch_bit);
    ps2k_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input int glitch_bit);
    model_frame(code, !bad_par && !bad_stop);
    send_bits(code, bad_par, bad_stop, 11, glitch_bit);
    wait_cyc(30);
    @(negedge clk_in);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [7:0] table_codes [6];
    table_codes = '{8'h1C, 8'h1B, 8'h23, 8'hF0, 8'hE0, 8'hF0};
    wait_cyc(5);
    @(negedge clk_in);
    chk("reset_byte", ps2_byte, 8'h00);
    chk("reset_state", ps2_state, 1'b0);
    chk("reset_valid", byte_valid, 1'b0);
    chk("reset_err", frame_err, 1'b0);
    reset = 1'b0;
    wait_cyc(20);

    send_frame(8'h1C, 0, 0, -1);
    chk("press_byte", ps2_byte, 8'h1C);
    chk("press_state", ps2_state, 1'b1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h1C, 0, 0, -1);
    chk("release_byte", ps2_byte, 8'h1C);
    chk("release_state", ps2_state, 1'b0);

    send_frame(8'h1C, 0, 0, -1);
    send_frame(8'h1B, 0, 0, -1);
    chk("overlap_byte", ps2_byte, 8'h1B);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h1C, 0, 0, -1);
    chk("overlap_hold_byte", ps2_byte, 8'h1B);
    chk("overlap_hold_state", ps2_state, 1'b1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h1B, 0, 0, -1);
    chk("overlap_release_state", ps2_state, 1'b0);

    send_frame(8'h1C, 1, 0, -1);
    send_frame(8'h1C, 0, 1, -1);
    chk("err_byte_kept", ps2_byte, 8'h1B);
    chk("err_state_kept", ps2_state, 1'b0);

    model_frame(8'h00, 0);
    send_bits(8'h1C, 0, 0, 5, -1);
    wait_cyc(TMO + 400);
    send_frame(8'h1B, 0, 0, -1);
    chk("after_timeout_byte", ps2_byte, 8'h1B);
    chk("after_timeout_state", ps2_state, 1'b1);

    send_frame(8'h1C, 0, 0, 4);
    chk("glitch_byte", ps2_byte, 8'h1C);

    chk("queue_before_reset", q.size(), 0);
    send_bits(8'h1B, 0, 0, 6, -1);
    reset = 1'b1;
    m_byte = 8'h00;
    m_state = 1'b0;
    m_brk = 1'b0;
    wait_cyc(3);
    ps2k_clk = 1'b1;
    ps2k_data = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    wait_cyc(20);
    @(negedge clk_in);
    chk("midreset_byte", ps2_byte, 8'h00);
    chk("midreset_state", ps2_state, 1'b0);
    send_frame(8'h1C, 0, 0, -1);
    chk("post_reset_byte", ps2_byte, 8'h1C);
    chk("post_reset_state", ps2_state, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] code;
      int         bad;
      code = table_codes[$urandom_range(0, 5)];
      bad  = $urandom_range(0, 15);
      send_frame(code, bad == 0, bad == 1, (bad == 2) ? int'($urandom_range(1, 9)) : -1);
    end

    wait_cyc(50);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 keyboard frames on ps2k_clk/ps2k_data, validates them and turns scan-code streams into a held-key byte plus key-down flag. It sits directly upstream of VGA_display, supplying ps2_byte/ps2_state that steer the paddle, in place of the raw-byte receiver. All logic runs on the 50 MHz board clock.

## Interface
- FILTER_LEN, 8, consecutive equal clk_in samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 50000, clk_in cycles (1 ms) allowed between PS/2 clock falling edges inside a frame.
- clk_in  input  1  50 MHz system clock.
- reset  input  1  asynchronous, active-high.
- ps2k_clk  input  1  PS/2 clock from keyboard, asynchronous.
- ps2k_data  input  1  PS/2 data from keyboard, asynchronous.
- ps2_byte  output  8  last accepted make code; held after release.
- ps2_state  output  1  1 while the key in ps2_byte is held down.
- byte_valid  output  1  one-cycle pulse per accepted make code, including typematic repeats.
- frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error.

## Operation
- Input conditioning: both PS/2 lines pass through a 2-FF synchronizer. The clock line then goes through a FILTER_LEN-deep glitch filter; the filtered level changes only when all FILTER_LEN samples agree.
- Bit sampling: a filtered-clock falling edge samples synchronized ps2k_data.
- Frame FSM states:
  - IDLE: an edge with data=0 (start bit) moves to DATA with bit count 0. An edge with data=1 is ignored and does not assert frame_err.
  - DATA: 8 edges, LSB first, shifted into the code register. Moves to PARITY after the 8th edge.
  - PARITY: one edge. Parity is odd, so XOR of the 8 data bits and the parity bit must equal 1.
  - STOP: one edge. Data must be 1. Returns to IDLE.
- Frame acceptance: a frame with good parity and a good stop bit is handed to the decoder. Any other frame pulses frame_err, returns to IDLE and is discarded.
- Timeout: in any non-IDLE state, a cycle counter is cleared on each edge. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE and pulses frame_err. The counter is 16 bits wide and saturates.
- Decoder, for each accepted code:
  - 0xF0: set break_pend. No output change.
  - 0xE0: set ext_pend. No output change. The flag is cleared after the next non-prefix code. Extended keys are reported by their low byte.
  - Other code with break_pend=0: ps2_byte←code, ps2_state←1, byte_valid pulse.
  - Other code with break_pend=1: if code==ps2_byte then ps2_state←0; ps2_byte is unchanged. break_pend clears in both cases. A release of a non-current key is otherwise ignored.
- Frame errors never clear break_pend or ext_pend.
- Reset: all outputs, the FSM, counters, the shift register, break_pend and ext_pend clear. The FSM enters IDLE. The filtered clock and the synchronizers reset to 1 (idle-high bus). Reset asserted mid-frame abandons the frame with no frame_err.

## Timing
- Edge detect latency is 2 (sync) + FILTER_LEN clk_in cycles after the PS/2 clock pin falls.
- The filtered edge is registered. The FSM acts in the cycle after the filtered level changes.
- ps2_byte, ps2_state, byte_valid and frame_err are registered. They update together exactly one clk_in cycle after the stop-bit (or failing) edge is processed.
- byte_valid and frame_err are high for exactly one cycle and are never high in the same cycle.
- The minimum legal PS/2 half-period at 50 MHz is 30 µs, far longer than the filter. Consecutive frames need no gap beyond the stop bit.

## Test plan
- Press: frame for 0x1C (start 0, data LSB first, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> ps2_byte=0x1C, ps2_state=1, one byte_valid pulse, frame_err stays 0.
- Release: frames 0xF0 then 0x1C after the press -> ps2_state=0, ps2_byte stays 0x1C, no byte_valid.
- Overlap: press 0x1C, press 0x1B (parity 1), then send F0 1C -> ps2_byte=0x1B, ps2_state stays 1. Then F0 1B -> ps2_state=0.
- Errors:
  - 0x1C with parity bit 1 -> one frame_err pulse, outputs unchanged.
  - 0x1C with stop bit 0 -> same result.
- Timeout and glitch:
  - Send start plus 4 data bits, then hold the clock high for 1.2 ms -> frame_err pulse. A following 0x1B frame is accepted.
  - A 3-cycle low glitch on ps2k_clk mid-frame -> no extra bit shifted, and the frame decodes correctly.
- Reset: assert reset after 6 bits of a frame -> all outputs 0, no frame_err. The next complete 0x1C frame is accepted normally.
